// File: rtl/edac_parity_tree.sv
// Multi-channel pipelined XOR parity/syndrome tree with optional sof..eof frame accumulation.
// Sideband (valid/mode/sof/eof) rides alongside the tree data and is resolved at the output stage.
module edac_parity_tree #(
   parameter int                           DATA_W     = 32,
   parameter int                           CHANNELS   = 7,
   parameter int                           MICRO_W    = 2,
   parameter int                           PIPE_EVERY = 2,
   parameter logic [CHANNELS*DATA_W-1:0]   MASKS      = '1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clkEn,
   input  logic                clr,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_mode,
   input  logic                in_sof,
   input  logic                in_eof,
   output logic                out_valid,
   output logic [CHANNELS-1:0] out_par,
   output logic                out_err
);

   function automatic int calc_layers(input int width, input int fan_in);
      int span;
      int n;
      span = 1;
      n    = 0;
      while (span < width) begin
         span = span * fan_in;
         n    = n + 1;
      end
      return n;
   endfunction

   function automatic int ipow(input int base, input int expo);
      int r;
      r = 1;
      for (int k = 0; k < expo; k++) r = r * base;
      return r;
   endfunction

   localparam int LAYERS = calc_layers(DATA_W, MICRO_W);
   localparam int PAD_W  = ipow(MICRO_W, LAYERS);
   localparam int PE_DIV = (PIPE_EVERY != 0) ? PIPE_EVERY : 1;

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   // Zero-padded, masked copy of the input word for every channel
   logic [CHANNELS-1:0][PAD_W-1:0] masked_in;

   always_comb begin
      masked_in = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         masked_in[c][DATA_W-1:0] = in_data & MASKS[c*DATA_W +: DATA_W];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LAYERS; gi++) begin : g_layer
         localparam int NIN  = ipow(MICRO_W, LAYERS - gi);
         localparam int NOUT = ipow(MICRO_W, LAYERS - gi - 1);
         localparam bit DO_REG = (PIPE_EVERY != 0) && (((gi + 1) % PE_DIV) == 0) && (gi < LAYERS - 1);

         logic [CHANNELS-1:0][NIN-1:0]  data_in;
         logic [CHANNELS-1:0][NOUT-1:0] node;
         logic [CHANNELS-1:0][NOUT-1:0] data_out;
         logic [3:0]                    sb_in;
         logic [3:0]                    sb_out;

         if (gi == 0) begin : g_src
            assign data_in = masked_in;
            assign sb_in   = {in_eof, in_sof, in_mode, in_valid};
         end else begin : g_chain
            assign data_in = g_layer[gi-1].data_out;
            assign sb_in   = g_layer[gi-1].sb_out;
         end

         always_comb begin
            node = '0;
            for (int c = 0; c < CHANNELS; c++) begin
               for (int n = 0; n < NOUT; n++) begin
                  node[c][n] = ^data_in[c][n*MICRO_W +: MICRO_W];
               end
            end
         end

         if (DO_REG) begin : g_reg
            // clr drops everything in flight, including a beat arriving on the same edge
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  data_out <= '0;
                  sb_out   <= '0;
               end else if (clkEn) begin
                  if (clr) begin
                     data_out <= '0;
                     sb_out   <= '0;
                  end else begin
                     data_out <= node;
                     sb_out   <= sb_in;
                  end
               end
            end
         end else begin : g_wire
            assign data_out = node;
            assign sb_out   = sb_in;
         end
      end
   endgenerate

   logic [CHANNELS-1:0] tree_par;
   logic [3:0]          tail_sb;

   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_tap
         assign tree_par[gi] = g_layer[LAYERS-1].data_out[gi][0];
      end
   endgenerate

   assign tail_sb = g_layer[LAYERS-1].sb_out;

   logic                sb_valid;
   logic                sb_mode;
   logic                sb_sof;
   logic                sb_eof;

   assign sb_valid = tail_sb[0];
   assign sb_mode  = tail_sb[1];
   assign sb_sof   = tail_sb[2];
   assign sb_eof   = tail_sb[3];

   state_t              state_reg;
   logic [CHANNELS-1:0] acc_reg;
   logic                out_valid_reg;
   logic                out_err_reg;
   logic [CHANNELS-1:0] out_par_reg;

   // Output stage: per-word results pass straight through; frame beats drive the IDLE/ACCUM machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         acc_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_err_reg   <= 1'b0;
         out_par_reg   <= '0;
      end else if (clkEn) begin
         if (clr) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_err_reg   <= 1'b0;
            out_par_reg   <= '0;
         end else begin
            out_valid_reg <= 1'b0;
            out_err_reg   <= 1'b0;
            if (sb_valid) begin
               if (!sb_mode) begin
                  out_valid_reg <= 1'b1;
                  out_par_reg   <= tree_par;
               end else begin
                  case (state_reg)
                     S_IDLE: begin
                        if (sb_sof && sb_eof) begin
                           out_valid_reg <= 1'b1;
                           out_par_reg   <= tree_par;
                        end else if (sb_sof) begin
                           acc_reg   <= tree_par;
                           state_reg <= S_ACCUM;
                        end else begin
                           out_err_reg <= 1'b1;
                        end
                     end
                     S_ACCUM: begin
                        if (sb_sof) begin
                           // A new sof abandons the open frame and restarts from this word
                           out_err_reg <= 1'b1;
                           acc_reg     <= tree_par;
                           if (sb_eof) begin
                              out_valid_reg <= 1'b1;
                              out_par_reg   <= tree_par;
                              state_reg     <= S_IDLE;
                           end
                        end else if (sb_eof) begin
                           out_valid_reg <= 1'b1;
                           out_par_reg   <= acc_reg ^ tree_par;
                           state_reg     <= S_IDLE;
                        end else begin
                           acc_reg <= acc_reg ^ tree_par;
                        end
                     end
                     default: state_reg <= S_IDLE;
                  endcase
               end
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_err   = out_err_reg;
   assign out_par   = out_par_reg;

endmodule

// File: tb/tb_edac_parity_tree.sv
// Scoreboard bench for edac_parity_tree: the driver predicts each beat's outcome and enabled-edge
// arrival from a frame-level parity model; the monitor checks every clock edge against that queue.
module tb_edac_parity_tree;

   localparam int          LAT   = 3;
   localparam logic [31:0] MASK0 = 32'hFFFF_FFFF;
   localparam logic [31:0] MASK1 = 32'h0000_FFFF;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        clkEn    = 1'b0;
   logic        clr      = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data  = '0;
   logic        in_mode  = 1'b0;
   logic        in_sof   = 1'b0;
   logic        in_eof   = 1'b0;
   logic        out_valid;
   logic [1:0]  out_par;
   logic        out_err;

   edac_parity_tree #(
      .DATA_W    (32),
      .CHANNELS  (2),
      .MICRO_W   (2),
      .PIPE_EVERY(2),
      .MASKS     ({MASK1, MASK0})
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clkEn    (clkEn),
      .clr      (clr),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .in_sof   (in_sof),
      .in_eof   (in_eof),
      .out_valid(out_valid),
      .out_par  (out_par),
      .out_err  (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      bit         v;
      bit         err;
      logic [1:0] par;
   } exp_t;

   exp_t       sb_q[$];
   int         checks  = 0;
   int         errors  = 0;
   int         en_cnt  = 0;
   bit         end_req = 1'b0;

   // Reference frame state: open frame flag and running XOR of word parities
   bit         in_frame = 1'b0;
   logic [1:0] acc      = '0;

   function automatic logic [1:0] word_par(input logic [31:0] d);
      logic [1:0] p;
      p[0] = ($countones(d & MASK0) % 2) == 1;
      p[1] = ($countones(d & MASK1) % 2) == 1;
      return p;
   endfunction

   task automatic push_exp(input bit v, input bit err, input logic [1:0] par);
      exp_t e;
      e.edge_n = en_cnt + LAT;
      e.v      = v;
      e.err    = err;
      e.par    = par;
      sb_q.push_back(e);
   endtask

   task automatic model_beat(input logic [31:0] d, input bit m, input bit s, input bit e);
      logic [1:0] p;
      p = word_par(d);
      if (!m) begin
         push_exp(1'b1, 1'b0, p);
      end else if (!in_frame) begin
         if (s && e) push_exp(1'b1, 1'b0, p);
         else if (s) begin
            in_frame = 1'b1;
            acc      = p;
         end else push_exp(1'b0, 1'b1, 2'b00);
      end else begin
         if (s) begin
            acc = p;
            if (e) begin
               push_exp(1'b1, 1'b1, p);
               in_frame = 1'b0;
            end else push_exp(1'b0, 1'b1, 2'b00);
         end else if (e) begin
            push_exp(1'b1, 1'b0, acc ^ p);
            in_frame = 1'b0;
         end else acc = acc ^ p;
      end
   endtask

   task automatic beat(input logic [31:0] d, input bit m, input bit s, input bit e);
      @(negedge clk);
      clkEn    = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      in_sof   = s;
      in_eof   = e;
      model_beat(d, m, s, e);
   endtask

   task automatic idle(input bit en);
      @(negedge clk);
      clkEn    = en;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_mode  = 1'($urandom_range(0, 1));
      in_sof   = 1'($urandom_range(0, 1));
      in_eof   = 1'($urandom_range(0, 1));
   endtask

   // clr with a complete 1-word frame on the same edge: the beat must be dropped
   task automatic do_clr();
      @(negedge clk);
      clkEn    = 1'b1;
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h1;
      in_mode  = 1'b1;
      in_sof   = 1'b1;
      in_eof   = 1'b1;
      in_frame = 1'b0;
      acc      = '0;
   endtask

   task automatic do_rst();
      @(negedge clk);
      clkEn    = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b0;
      #2;
      rst      = 1'b1;
      in_frame = 1'b0;
      acc      = '0;
      @(negedge clk);
      rst      = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s at enabled edge %0d: got %0h, expected %0h", name, en_cnt, act, exp_v);
      end
   endtask

   // Monitor: sole owner of the counters; expected output state is ev/ee/ep
   logic       ev = 1'b0;
   logic       ee = 1'b0;
   logic [1:0] ep = '0;
   bit         s_rst;
   bit         s_en;
   bit         s_clr;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (!clk) begin
            #1;
            sb_q.delete();
            ev = 1'b0;
            ee = 1'b0;
            ep = '0;
            chk("async_rst_valid", 32'(out_valid), 32'(ev));
            chk("async_rst_err",   32'(out_err),   32'(ee));
            chk("async_rst_par",   32'(out_par),   32'(ep));
         end else begin
            s_rst = rst;
            s_en  = clkEn;
            s_clr = clr;
            #1;
            if (s_rst) begin
               sb_q.delete();
               ev = 1'b0;
               ee = 1'b0;
               ep = '0;
               chk("rst_valid", 32'(out_valid), 32'(ev));
               chk("rst_err",   32'(out_err),   32'(ee));
               chk("rst_par",   32'(out_par),   32'(ep));
            end else if (s_en) begin
               en_cnt++;
               ev = 1'b0;
               ee = 1'b0;
               if (s_clr) begin
                  sb_q.delete();
                  ep = '0;
               end else if (sb_q.size() > 0 && sb_q[0].edge_n == en_cnt) begin
                  exp_t e;
                  e  = sb_q.pop_front();
                  ev = e.v;
                  ee = e.err;
                  if (e.v) ep = e.par;
                  $display("txn edge %0d: expect valid=%b err=%b par=%b, got valid=%b err=%b par=%b",
                           en_cnt, ev, ee, ep, out_valid, out_err, out_par);
               end
               chk("out_valid", 32'(out_valid), 32'(ev));
               chk("out_err",   32'(out_err),   32'(ee));
               chk("out_par",   32'(out_par),   32'(ep));
               if (end_req) begin
                  chk("queue_empty", 32'(sb_q.size()), 32'd0);
                  $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                  $finish;
               end
            end else begin
               chk("hold_valid", 32'(out_valid), 32'(ev));
               chk("hold_err",   32'(out_err),   32'(ee));
               chk("hold_par",   32'(out_par),   32'(ep));
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(1'b1);

      // Single mode 0 beat, then back-to-back mode 0 beats
      beat(32'h0000_0001, 1'b0, 1'b0, 1'b0);
      repeat (4) idle(1'b1);
      beat(32'h0001_0000, 1'b0, 1'b0, 1'b0);
      beat(32'h0000_0003, 1'b0, 1'b0, 1'b0);
      beat(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      repeat (4) idle(1'b1);

      // Three-word frame
      beat(32'h0000_0001, 1'b1, 1'b1, 1'b0);
      beat(32'h0000_0003, 1'b1, 1'b0, 1'b0);
      beat(32'h0001_0000, 1'b1, 1'b0, 1'b1);
      repeat (4) idle(1'b1);

      // sof inside an open frame, then eof-only while idle
      beat(32'h0000_0001, 1'b1, 1'b1, 1'b0);
      beat(32'h0001_0000, 1'b1, 1'b1, 1'b0);
      beat(32'h0000_0003, 1'b1, 1'b0, 1'b1);
      beat(32'h0000_0005, 1'b1, 1'b0, 1'b1);
      repeat (4) idle(1'b1);

      // Mode 0 beat interleaved inside an open frame must not disturb it
      beat(32'h0000_0001, 1'b1, 1'b1, 1'b0);
      beat(32'h0000_0007, 1'b0, 1'b0, 1'b0);
      beat(32'h0003_0000, 1'b1, 1'b0, 1'b1);
      repeat (4) idle(1'b1);

      // Stall: clkEn low for 4 cycles, one cycle after the beat enters
      beat(32'h0000_0001, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      repeat (4) idle(1'b0);
      repeat (4) idle(1'b1);
      beat(32'h0001_0001, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      repeat (3) idle(1'b0);
      repeat (3) idle(1'b1);

      // Async reset mid-frame with two beats in flight
      beat(32'h0000_0001, 1'b1, 1'b1, 1'b0);
      beat(32'h0000_0003, 1'b1, 1'b0, 1'b0);
      do_rst();
      beat(32'h0000_0001, 1'b1, 1'b1, 1'b1);
      repeat (4) idle(1'b1);

      // Same scenario with clr
      beat(32'h0000_0001, 1'b1, 1'b1, 1'b0);
      beat(32'h0000_0003, 1'b1, 1'b0, 1'b0);
      do_clr();
      beat(32'h0000_0001, 1'b1, 1'b1, 1'b1);
      repeat (4) idle(1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 8) idle(1'b0);
         else if (r < 14) idle(1'b1);
         else if (r < 16) do_clr();
         else if (r == 16) do_rst();
         else beat($urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end

      repeat (6) idle(1'b1);
      end_req = 1'b1;
      repeat (4) idle(1'b1);
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule
